alu_pipe: RTL

- Parametrised, registered successor to the team's combinational 8-bit ALU.
- Same base operation set, plus shifts, an iterative multiply, status flags and valid/ready handshakes on input and output.
- Sits between the register-file read stage and the write-back stage of the datapath.
- Only one operation is in flight at a time; the block stalls cleanly under back-pressure.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_iter.sv | 57 +++++
 rtl/alu_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the pipelined ALU.
package alu_pkg;

   // Operation codes; all eight encodings are defined, so no code is illegal.
   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_NOT = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } op_t;

   // IDLE accepts work; BUSY runs the iterative multiplier.
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Bit positions inside the packed status-flag vector.
   localparam int FLAG_Z    = 0;
   localparam int FLAG_N    = 1;
   localparam int FLAG_C    = 2;
   localparam int FLAG_V    = 3;
   localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier: one partial-product step per clock.
// 'start' loads the operands; 'done' is high during the final step, and
// 'product' shows the accumulator value that step produces, so the caller
// can register the finished product on the same edge.
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);

   logic                busy_q;
   logic [CW-1:0]       cnt_q;
   logic [WIDTH-1:0]    mcand_q;
   logic [2*WIDTH-1:0]  acc_q;
   logic [2*WIDTH-1:0]  acc_d;
   logic [WIDTH:0]      sum;

   // One step: add the multiplicand into the upper half when the current
   // multiplier bit (acc lsb) is set, then shift the whole accumulator right.
   always_comb begin
      sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_d = {sum, acc_q[WIDTH-1:1]};
   end

   // Operand capture, accumulator and iteration counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         mcand_q <= '0;
         acc_q   <= '0;
      end else if (start) begin
         busy_q  <= 1'b1;
         cnt_q   <= CW'(WIDTH - 1);
         mcand_q <= a;
         acc_q   <= {{WIDTH{1'b0}}, b};
      end else if (busy_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == '0) begin
            busy_q <= 1'b0;
         end
      end
   end

   assign done    = busy_q && (cnt_q == '0);
   assign product = acc_d;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes on both sides. Single-cycle
// operations load the output register on acceptance; MUL runs in the
// iterative multiplier and loads the output register when it finishes.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        op,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              flag_z,
   output logic              flag_n,
   output logic              flag_c,
   output logic              flag_v
);

   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

   state_t                  state_q;
   state_t                  state_d;
   op_t                     op_e;
   logic                    accept;
   logic                    mul_start;
   logic                    mul_done;
   logic [2*WIDTH-1:0]      mul_product;

   logic [WIDTH-1:0]        alu_res;
   logic                    alu_c;
   logic                    alu_v;
   logic [WIDTH:0]          add_w;
   logic [WIDTH:0]          sub_w;
   logic [2*WIDTH-1:0]      shl_w;
   logic [2*WIDTH-1:0]      shr_w;

   logic                    load;
   logic [WIDTH-1:0]        res_d;
   logic [NUM_FLAGS-1:0]    flags_d;
   logic [NUM_FLAGS-1:0]    flags_q;

   assign op_e = op_t'(op);

   // Ready only in IDLE with a free (or draining) output slot, never in reset.
   assign in_ready  = rst_n && (state_q == IDLE) && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign mul_start = accept && (op_e == OP_MUL);

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Single-cycle datapath: result, carry and overflow for every non-MUL op.
   always_comb begin
      // NOTE: every signal written here is given a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      add_w   = {1'b0, a} + {1'b0, b};
      sub_w   = {1'b0, a} - {1'b0, b};
      shl_w   = {{WIDTH{1'b0}}, a} << b[SHW-1:0];
      shr_w   = {a, {WIDTH{1'b0}}} >> b[SHW-1:0];
      case (op_e)
         OP_ADD: begin
            alu_res = add_w[WIDTH-1:0];
            alu_c   = add_w[WIDTH];
            alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = sub_w[WIDTH-1:0];
            alu_c   = sub_w[WIDTH];
            alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: alu_res = a & b;
         OP_OR:  alu_res = a | b;
         OP_NOT: alu_res = ~a;
         OP_SHL: begin
            if (b >= WIDTH_V) begin
               alu_c = |a;
            end else begin
               alu_res = shl_w[WIDTH-1:0];
               alu_c   = |shl_w[2*WIDTH-1:WIDTH];
            end
         end
         OP_SHR: begin
            if (b >= WIDTH_V) begin
               alu_c = |a;
            end else begin
               alu_res = shr_w[2*WIDTH-1:WIDTH];
               alu_c   = |shr_w[WIDTH-1:0];
            end
         end
         default: ;
      endcase
   end

   // Output-register source select: finished MUL or an accepted single-cycle op.
   always_comb begin
      load    = 1'b0;
      res_d   = '0;
      flags_d = '0;
      if (mul_done) begin
         load            = 1'b1;
         res_d           = mul_product[WIDTH-1:0];
         flags_d[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
      end else if (accept && (op_e != OP_MUL)) begin
         load            = 1'b1;
         res_d           = alu_res;
         flags_d[FLAG_C] = alu_c;
         flags_d[FLAG_V] = alu_v;
      end
      flags_d[FLAG_Z] = load && (res_d == '0);
      flags_d[FLAG_N] = res_d[WIDTH-1];
   end

   // Output register: loads new work, clears on drain, holds under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         flags_q   <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         result    <= res_d;
         flags_q   <= flags_d;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   assign flag_z = flags_q[FLAG_Z];
   assign flag_n = flags_q[FLAG_N];
   assign flag_c = flags_q[FLAG_C];
   assign flag_v = flags_q[FLAG_V];

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block evaluation order.
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: MUL enters BUSY, the multiplier's last step returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (mul_start) state_d = BUSY;
         BUSY:    if (mul_done)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

endmodule
